// File: rtl/if_stage_prefetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : if_stage_prefetch
// Purpose  : Instruction fetch stage with a DEPTH-entry prefetch FIFO that
//            feeds decode over valid/ready. Optional macro: IFS_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module if_stage_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Branch,
    input  logic              Jump,
    input  logic [ADDR_W-1:0] BranchOffset,
    input  logic [25:0]       JumpAddress,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic [DATA_W-1:0] IMemData,
    output logic              InstValid,
    input  logic              InstReady,
    output logic [DATA_W-1:0] Inst,
    output logic [ADDR_W-1:0] InstPC
`ifdef IFS_PERF_CNT_EN
    ,
    output logic [31:0]       PerfFetched,
    output logic [31:0]       PerfStall,
    output logic [15:0]       PerfFlush
`endif
);

    localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  c_DEPTH = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_FOUR  = ADDR_W'(4);

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_pc   [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_fpc;
    logic [ADDR_W-1:0] r_if_pc;
    logic              r_inflight;

    logic [CNT_W-1:0]  w_credit_used;
    logic              w_valid;
    logic              w_redirect;
    logic              w_req;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_head_pc;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_jmp_tgt;
    logic [ADDR_W-1:0] w_target;

    // Credit counts the in-flight word so a full FIFO can never be overrun.
    assign w_credit_used = r_cnt + {{(CNT_W-1){1'b0}}, r_inflight};
    assign w_valid       = (r_cnt != '0);
    assign w_redirect    = w_valid && (Branch || Jump);
    assign w_req         = Rst_n && (w_credit_used < c_DEPTH) && !w_redirect;
    assign w_push        = r_inflight && !w_redirect;
    assign w_pop         = w_valid && InstReady && !w_redirect;

    assign w_head_pc  = r_pc[r_rd_ptr];
    assign w_pc_plus4 = w_head_pc + c_FOUR;
    assign w_br_tgt   = w_pc_plus4 + (BranchOffset << 2);

    generate
        if (ADDR_W > 28) begin : g_jmp_region
            assign w_jmp_tgt = {w_pc_plus4[ADDR_W-1:28], JumpAddress, 2'b00};
        end else begin : g_jmp_flat
            assign w_jmp_tgt = {JumpAddress, 2'b00};
        end
    endgenerate

    assign w_target = Jump ? w_jmp_tgt : w_br_tgt;

    assign IMemReq   = w_req;
    assign IMemAddr  = r_fpc;
    assign InstValid = w_valid;
    assign Inst      = r_data[r_rd_ptr];
    assign InstPC    = w_head_pc;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_fpc      <= RESET_PC;
            r_if_pc    <= '0;
            r_inflight <= 1'b0;
            r_cnt      <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_if_pc <= r_fpc;
            end
            if (w_redirect) begin
                r_fpc    <= w_target;
                r_cnt    <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_req) begin
                    r_fpc <= r_fpc + c_FOUR;
                end
                if (w_push) begin
                    r_data[r_wr_ptr] <= IMemData;
                    r_pc[r_wr_ptr]   <= r_if_pc;
                    r_wr_ptr         <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

`ifdef IFS_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_flush;

    // A redirect consumes the head, so it counts as a fetched instruction.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
            r_perf_flush   <= '0;
        end else begin
            if (w_pop || w_redirect) begin
                r_perf_fetched <= r_perf_fetched + 1'b1;
            end
            if (w_valid && !InstReady && !w_redirect) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            if (w_redirect) begin
                r_perf_flush <= r_perf_flush + 1'b1;
            end
        end
    end

    assign PerfFetched = r_perf_fetched;
    assign PerfStall   = r_perf_stall;
    assign PerfFlush   = r_perf_flush;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage_prefetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_if_stage_prefetch
// Purpose  : Directed + random bench for if_stage_prefetch against a
//            request-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_if_stage_prefetch;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Branch = 1'b0;
    logic        Jump = 1'b0;
    logic [31:0] BranchOffset = '0;
    logic [25:0] JumpAddress = '0;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemData = '0;
    logic        InstValid;
    logic        InstReady = 1'b0;
    logic [31:0] Inst;
    logic [31:0] InstPC;
`ifdef IFS_PERF_CNT_EN
    logic [31:0] PerfFetched;
    logic [31:0] PerfStall;
    logic [15:0] PerfFlush;
`endif

    if_stage_prefetch #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) u_dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Branch      (Branch),
        .Jump        (Jump),
        .BranchOffset(BranchOffset),
        .JumpAddress (JumpAddress),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .IMemData    (IMemData),
        .InstValid   (InstValid),
        .InstReady   (InstReady),
        .Inst        (Inst),
        .InstPC      (InstPC)
`ifdef IFS_PERF_CNT_EN
        ,
        .PerfFetched (PerfFetched),
        .PerfStall   (PerfStall),
        .PerfFlush   (PerfFlush)
`endif
    );

    always #5 Clk = ~Clk;

    // Synchronous instruction memory, one-cycle latency.
    always @(posedge Clk) begin
        if (IMemReq) IMemData <= {16'hA5A5, IMemAddr[15:0]};
    end

    // Reference model: every issued request waits in a queue until popped;
    // its word becomes visible two edges after issue.
    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } req_t;

    req_t        q[$];
    logic [31:0] m_fpc;
    int          cyc;
    int          m_fetched, m_stall, m_flush;
    int          n_tests, n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].cyc <= cyc - 2);
    endfunction

    task automatic model_reset();
        q.delete();
        m_fpc = 32'h0;
        cyc = 0;
        m_fetched = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Called at posedge+1: drive, check at negedge, advance model after edge.
    task automatic cycle(input logic br, input logic jp, input logic [31:0] off,
                         input logic [25:0] ja, input logic rdy);
        bit          ev, redir, er;
        logic [31:0] pc4, tgt;
        req_t        e;
        Branch = br; Jump = jp; BranchOffset = off; JumpAddress = ja; InstReady = rdy;
        @(negedge Clk);
        ev    = m_valid();
        redir = ev && (br || jp);
        er    = (q.size() < DEPTH) && !redir;
        check("imem_req", IMemReq, er);
        if (er) check("imem_addr", IMemAddr, m_fpc);
        check("inst_valid", InstValid, ev);
        if (ev) begin
            check("inst_pc", InstPC, q[0].pc);
            check("inst", Inst, {16'hA5A5, q[0].pc[15:0]});
        end
        @(posedge Clk);
        #1;
        if (ev && (rdy || redir)) m_fetched++;
        if (ev && !rdy && !redir) m_stall++;
        if (redir) begin
            m_flush++;
            pc4 = q[0].pc + 32'd4;
            tgt = jp ? {pc4[31:28], ja, 2'b00} : pc4 + off * 32'd4;
            q.delete();
            m_fpc = tgt;
        end else begin
            if (ev && rdy) void'(q.pop_front());
            if (er) begin
                e.pc = m_fpc;
                e.cyc = cyc;
                q.push_back(e);
                m_fpc = m_fpc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run_until_head(input logic [31:0] pc, input int budget);
        int n = 0;
        while (!(m_valid() && q[0].pc == pc) && n < budget) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1);
            n++;
        end
        check("reach_head_pc", InstPC, pc);
    endtask

    task automatic run_until_valid(input int budget);
        int n = 0;
        while (!m_valid() && n < budget) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b1);
            n++;
        end
        check("reach_valid", InstValid, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, IMemReq, 1'b0);
        check({tag, "_valid"}, InstValid, 1'b0);
        check({tag, "_inst"}, Inst, 32'h0);
        check({tag, "_pc"}, InstPC, 32'h0);
`ifdef IFS_PERF_CNT_EN
        check({tag, "_perf_fetched"}, PerfFetched, 32'h0);
        check({tag, "_perf_stall"}, PerfStall, 32'h0);
        check({tag, "_perf_flush"}, {16'h0, PerfFlush}, 32'h0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] h;
        n_tests = 0;
        n_fail  = 0;
        model_reset();

        // Power-on reset
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Rst_n = 1'b1;

        // Straight-line streaming, then branch at PC 0x8 with offset 3
        run_until_head(32'h8, 8);
        cycle(1'b1, 1'b0, 32'd3, '0, 1'b1);
        // Head is invalid right after a flush: these must be ignored
        cycle(1'b1, 1'b0, 32'd5, '0, 1'b1);
        cycle(1'b0, 1'b1, '0, 26'h123, 1'b0);
        check("after_branch_pc", InstPC, 32'h18);
        check("after_branch_valid", InstValid, 1'b1);

        // Jump to 0x10, then Jump+Branch together at 0x10: Jump wins
        cycle(1'b0, 1'b1, '0, 26'h4, 1'b1);
        run_until_head(32'h10, 4);
        cycle(1'b1, 1'b1, 32'd3, 26'h40, 1'b1);
        run_until_head(32'h100, 4);
        check("jump_inst", Inst, 32'hA5A50100);

        // Decode stalls: buffer fills, head holds, then streams again
        run_until_valid(4);
        h = q[0].pc;
        repeat (10) cycle(1'b0, 1'b0, '0, '0, 1'b0);
        check("stall_req_off", IMemReq, 1'b0);
        check("stall_head_pc", InstPC, h);
        check("stall_head_inst", Inst, {16'hA5A5, h[15:0]});
        repeat (8) cycle(1'b0, 1'b0, '0, '0, 1'b1);

        // Branch to the top word, then branch past it with offset 0 (wrap)
        run_until_valid(4);
        h = q[0].pc;
        cycle(1'b1, 1'b0, (32'hFFFFFFFC - h - 32'd4) >> 2, '0, 1'b1);
        run_until_head(32'hFFFFFFFC, 4);
        check("top_inst", Inst, 32'hA5A5FFFC);
        cycle(1'b1, 1'b0, 32'd0, '0, 1'b1);
        run_until_head(32'h0, 4);
        check("wrap_inst", Inst, 32'hA5A50000);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0),
                  32'($urandom_range(0, 63)) - 32'd32, 26'($urandom), ($urandom_range(0, 9) < 7));
        end
`ifdef IFS_PERF_CNT_EN
        check("perf_fetched", PerfFetched, m_fetched);
        check("perf_stall", PerfStall, m_stall);
        check("perf_flush", {16'h0, PerfFlush}, m_flush);
`endif

        // Fill the buffer, then reset asynchronously mid-cycle
        repeat (8) cycle(1'b0, 1'b0, '0, '0, 1'b0);
        check("full_before_reset", InstValid, 1'b1);
        #2;
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(posedge Clk);
        #1;
        check("midreset_hold_valid", InstValid, 1'b0);
        Rst_n = 1'b1;
        repeat (8) cycle(1'b0, 1'b0, '0, '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
